// File: rtl/systolic_sweep_driver.sv
// Initiator for a combinational systolic array: drives row/column operands, waits a
// settle interval, samples the array output and returns it over valid/ready.
module systolic_sweep_driver #(
    parameter int ROW    = 4,
    parameter int COLUMN = 11,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ROW+COLUMN-1:0] vec_in,
    output logic [ROW-1:0]        arr_row,
    output logic [COLUMN-1:0]     arr_col,
    input  logic                  arr_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_bit,
    output logic [ROW+COLUMN-1:0] res_vec,
    output logic                  busy,
    output logic                  done,
    output logic [ROW+COLUMN:0]   ones_count,
    output logic [15:0]           signature
);

    localparam int VW = ROW + COLUMN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] vec_q, vec_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          res_bit_q, res_bit_d;
    logic [VW-1:0] res_vec_q, res_vec_d;
    logic          res_valid_q, res_valid_d;
    logic [VW:0]   ones_q, ones_d;
    logic [15:0]   sig_q, sig_d;
    logic          handshake;
    logic          last_vec;

    // Serial-input MISR, feedback polynomial taps 0x002D.
    function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic b);
        return {sig[14:0], 1'b0} ^ (sig[15] ? 16'h002D : 16'h0000) ^ {15'b0, b};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            res_bit_q   <= 1'b0;
            res_vec_q   <= '0;
            res_valid_q <= 1'b0;
            ones_q      <= '0;
            sig_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            res_bit_q   <= res_bit_d;
            res_vec_q   <= res_vec_d;
            res_valid_q <= res_valid_d;
            ones_q      <= ones_d;
            sig_q       <= sig_d;
        end
    end

    assign handshake = res_valid_q & res_ready;
    // A sweep ends on the all-ones vector, so vec never wraps.
    assign last_vec  = ~mode_q | (&vec_q);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        res_bit_d   = res_bit_q;
        res_vec_d   = res_vec_q;
        res_valid_d = res_valid_q;
        ones_d      = ones_q;
        sig_d       = sig_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d   = mode ? '0 : vec_in;
                    mode_d  = mode;
                    ones_d  = '0;
                    sig_d   = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_bit_d   = arr_out;
                    res_vec_d   = vec_q;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (handshake) begin
                    res_valid_d = 1'b0;
                    ones_d      = ones_q + {{VW{1'b0}}, res_bit_q};
                    sig_d       = misr_next(sig_q, res_bit_q);
                    if (last_vec) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign arr_row    = vec_q[ROW-1:0];
    assign arr_col    = vec_q[VW-1:ROW];
    assign res_valid  = res_valid_q;
    assign res_bit    = res_bit_q;
    assign res_vec    = res_vec_q;
    assign ones_count = ones_q;
    assign signature  = sig_q;

endmodule

// File: tb/tb_systolic_sweep_driver.sv
// Scoreboard bench for systolic_sweep_driver: a default-size instance for single-vector,
// backpressure and abort behaviour, and a small instance for complete sweeps.
module tb_systolic_sweep_driver;

    localparam int R  = 4,  C  = 11, S  = 2, N  = R + C;
    localparam int R2 = 2,  C2 = 3,  S2 = 3, N2 = R2 + C2;

    typedef struct {
        int unsigned vec;
        bit          b;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, mode, res_ready, arr_out;
    logic [N-1:0]  vec_in;
    logic [R-1:0]  arr_row;
    logic [C-1:0]  arr_col;
    logic          res_valid, res_bit, busy, done;
    logic [N-1:0]  res_vec;
    logic [N:0]    ones_count;
    logic [15:0]   signature;

    logic          start2, mode2, res_ready2, arr_out2;
    logic [N2-1:0] vec_in2;
    logic [R2-1:0] arr_row2;
    logic [C2-1:0] arr_col2;
    logic          res_valid2, res_bit2, busy2, done2;
    logic [N2-1:0] res_vec2;
    logic [N2:0]   ones_count2;
    logic [15:0]   signature2;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt1 = 0;
    int   done_cnt2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    // Stand-in for the combinational array: a fixed mixing function of the operands.
    function automatic bit arr_model(input int unsigned v);
        return (^(v & 32'h5A3C_9E17)) ^ (v[0] & v[3]);
    endfunction

    function automatic int unsigned misr_step(input int unsigned s, input bit b);
        int unsigned fb;
        fb = (s / 32768 != 0) ? 32'h2D : 32'h0;
        return ((s * 2) % 65536) ^ fb ^ int'(b);
    endfunction

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    assign arr_out  = arr_model(32'({arr_col, arr_row}));
    assign arr_out2 = arr_model(32'({arr_col2, arr_row2}));

    systolic_sweep_driver #(.ROW(R), .COLUMN(C), .SETTLE(S)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .vec_in(vec_in),
        .arr_row(arr_row), .arr_col(arr_col), .arr_out(arr_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit), .res_vec(res_vec),
        .busy(busy), .done(done), .ones_count(ones_count), .signature(signature)
    );

    systolic_sweep_driver #(.ROW(R2), .COLUMN(C2), .SETTLE(S2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .vec_in(vec_in2),
        .arr_row(arr_row2), .arr_col(arr_col2), .arr_out(arr_out2),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_bit(res_bit2), .res_vec(res_vec2),
        .busy(busy2), .done(done2), .ones_count(ones_count2), .signature(signature2)
    );

    // Monitors: every accepted result is popped from its scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sb1_res_vec", 64'(res_vec), 64'(e.vec));
                check("sb1_res_bit", 64'(res_bit), 64'(e.b));
            end
        end
        if (done) done_cnt1++;
    end

    always @(negedge clk) begin
        if (!reset && res_valid2 && res_ready2) begin
            if (q2.size() == 0) begin
                check("sb2_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("sb2_res_vec", 64'(res_vec2), 64'(e.vec));
                check("sb2_res_bit", 64'(res_bit2), 64'(e.b));
            end
        end
        if (done2) done_cnt2++;
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_res_valid"}, 64'(res_valid), 0);
        check({tag, "_res_bit"}, 64'(res_bit), 0);
        check({tag, "_res_vec"}, 64'(res_vec), 0);
        check({tag, "_arr_row"}, 64'(arr_row), 0);
        check({tag, "_arr_col"}, 64'(arr_col), 0);
        check({tag, "_ones"}, 64'(ones_count), 0);
        check({tag, "_sig"}, 64'(signature), 0);
    endtask

    // Single-vector run with exact cycle-by-cycle timing from the start cycle.
    task automatic t_single(input logic [N-1:0] v, input string tag);
        bit b;
        b = arr_model(32'(v));
        q1.push_back('{32'(v), b});
        res_ready = 1'b1;
        mode      = 1'b0;
        vec_in    = v;
        start     = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        vec_in = N'($urandom);
        check({tag, "_c1_busy"}, 64'(busy), 1);
        check({tag, "_c1_valid"}, 64'(res_valid), 0);
        check({tag, "_c1_arr_row"}, 64'(arr_row), 64'(v[R-1:0]));
        check({tag, "_c1_arr_col"}, 64'(arr_col), 64'(v[N-1:R]));
        @(posedge clk); #1;
        check({tag, "_c2_valid"}, 64'(res_valid), 0);
        @(posedge clk); #1;
        check({tag, "_c3_valid"}, 64'(res_valid), 1);
        check({tag, "_c3_res_vec"}, 64'(res_vec), 64'(v));
        check({tag, "_c3_res_bit"}, 64'(res_bit), 64'(b));
        @(posedge clk); #1;
        check({tag, "_c4_done"}, 64'(done), 1);
        check({tag, "_c4_valid"}, 64'(res_valid), 0);
        check({tag, "_c4_ones"}, 64'(ones_count), 64'(b));
        check({tag, "_c4_sig"}, 64'(signature), 64'(b));
        @(posedge clk); #1;
        check({tag, "_c5_done"}, 64'(done), 0);
        check({tag, "_c5_busy"}, 64'(busy), 0);
        check({tag, "_c5_ones_hold"}, 64'(ones_count), 64'(b));
    endtask

    // Full sweep of the small instance; ready is held high or randomised.
    task automatic sweep2(input bit rand_ready, input string tag);
        int unsigned eo, es;
        int          cyc;
        eo = 0;
        es = 0;
        for (int v = 0; v < (1 << N2); v++) begin
            bit b;
            b = arr_model(32'(v));
            q2.push_back('{32'(v), b});
            eo += int'(b);
            es = misr_step(es, b);
        end
        res_ready2 = 1'b1;
        mode2      = 1'b1;
        vec_in2    = N2'($urandom);
        start2     = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc    = 1;
        while (!done2 && cyc < 2000) begin
            start2 = (cyc == 50);
            mode2  = 1'b0;
            if (rand_ready) res_ready2 = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        start2     = 1'b0;
        res_ready2 = 1'b1;
        check({tag, "_done_seen"}, 64'(done2), 1);
        if (!rand_ready) check({tag, "_done_cycle"}, 64'(cyc), 64'((1 << N2) * (S2 + 1) + 1));
        check({tag, "_ones"}, 64'(ones_count2), 64'(eo));
        check({tag, "_sig"}, 64'(signature2), 64'(es));
        check({tag, "_queue_drained"}, 64'(q2.size()), 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse_len"}, 64'(done2), 0);
        check({tag, "_idle"}, 64'(busy2), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        bit   hit, bp_done;
        logic [N-1:0] rv;
        logic rb;

        reset = 1'b1; start = 1'b0; mode = 1'b0; vec_in = '0; res_ready = 1'b0;
        start2 = 1'b0; mode2 = 1'b0; vec_in2 = '0; res_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        check("rst_busy2", 64'(busy2), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        t_single('0, "t1");
        t_single({N{1'b1}}, "t2");

        // Randomised sweep with one backpressure window, an ignored start, and an abort.
        res_ready = 1'b0;
        mode      = 1'b1;
        vec_in    = N'($urandom);
        for (int v = 0; v <= 'h123; v++) q1.push_back('{32'(v), arr_model(32'(v))});
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cyc     = 0;
        hit     = 1'b0;
        bp_done = 1'b0;
        while (!hit && cyc < 20000) begin
            if (res_valid && res_vec == N'('h123)) begin
                hit       = 1'b1;
                res_ready = 1'b0;
            end else if (res_valid && res_vec == N'(5) && !bp_done) begin
                res_ready = 1'b0;
                rv = res_vec;
                rb = res_bit;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("t4_valid_hold", 64'(res_valid), 1);
                    check("t4_res_vec_hold", 64'(res_vec), 5);
                    check("t4_res_bit_hold", 64'(res_bit), 64'(rb));
                    check("t4_vec_hold", 64'({arr_col, arr_row}), 64'(rv));
                end
                check("t4_res_bit_model", 64'(rb), 64'(arr_model(5)));
                bp_done   = 1'b1;
                res_ready = 1'b1;
            end else begin
                res_ready = ($urandom_range(0, 3) != 0);
                start     = (cyc == 40);
                mode      = 1'b0;
                vec_in    = N'($urandom);
            end
            if (!hit) begin
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end
        end
        check("t6_reached_0123", 64'(hit), 1);
        check("t6_valid_before_abort", 64'(res_valid), 1);
        check("t6_pending_results", 64'(q1.size()), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("t6");
        q1.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        check("t6_no_done_after_abort", 64'(done), 0);
        t_single('0, "t6_restart");

        sweep2(1'b0, "t3");
        sweep2(1'b1, "t3_rand");

        check("done_pulses_dut", 64'(done_cnt1), 3);
        check("done_pulses_dut2", 64'(done_cnt2), 2);
        check("sb1_drained", 64'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
